spi_slave_responder: RTL

- SPI responder (target) for an external SPI initiator; it is the far-end counterpart of the SoC's spi0 master.
- Samples io_spi_sclk, io_spi_ss and io_spi_mosi, shifts words in and out, and presents them to the system side as an RX valid pulse and a TX valid/ready stream.
- Fixed SPI mode 0: CPOL=0, CPHA=0, MSB first.
- The whole block runs in the system clock domain; the SPI pins are oversampled through synchronizers.

---
 rtl/spi_slave_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder running entirely in the system clock domain; SPI pins are oversampled.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN adds io_spi_miso_writeEnable for a shared MISO line.
module spi_slave_responder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '1
) (
  input  logic                  io_sys_clock,
  input  logic                  io_sys_reset,
  input  logic                  io_spi_sclk,
  input  logic                  io_spi_ss,
  input  logic                  io_spi_mosi,
  output logic                  io_spi_miso,
  input  logic                  io_tx_valid,
  output logic                  io_tx_ready,
  input  logic [DATA_WIDTH-1:0] io_tx_payload,
  output logic                  io_rx_valid,
  output logic [DATA_WIDTH-1:0] io_rx_payload,
  output logic                  io_tx_underrun,
  output logic                  io_busy
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  ,
  output logic                  io_spi_miso_writeEnable
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    ss_prev_q, ss_prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic                    word_done_q, word_done_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]   rx_payload_q, rx_payload_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_underrun_q, tx_underrun_d;

  logic                    sclk_s, ss_s, mosi_s;
  logic                    sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                    load_word, tx_accept;
  logic [DATA_WIDTH-1:0]   rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign rx_next   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  assign tx_accept = io_tx_valid & ~hold_full_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], io_spi_sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], io_spi_ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], io_spi_mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    word_done_d   = word_done_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_payload_d  = rx_payload_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    load_word     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        rx_shift_d  = '0;
        word_done_d = 1'b0;
        if (ss_fall) begin
          load_word = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // ss release outranks any sclk edge seen in the same cycle; a partial word is dropped
        if (ss_rise) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          word_done_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d        = '0;
            word_done_d  = 1'b1;
            rx_payload_d = rx_next;
            rx_valid_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            load_word   = 1'b1;
            word_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_word) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d    = IDLE_WORD;
        tx_underrun_d = 1'b1;
      end
    end

    // ready comes from the pre-consume state, so a consume cycle never also accepts
    if (tx_accept) begin
      hold_full_d = 1'b1;
      hold_d      = io_tx_payload;
    end
  end

  always_ff @(posedge io_sys_clock) begin
    if (io_sys_reset) begin
      state_q       <= ST_IDLE;
      sclk_sync_q   <= '0;
      // ss chain resets to the deasserted level so the block starts idle and not busy
      ss_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      ss_prev_q     <= 1'b1;
      cnt_q         <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      word_done_q   <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_payload_q  <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      ss_prev_q     <= ss_prev_d;
      cnt_q         <= cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      word_done_q   <= word_done_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_payload_q  <= rx_payload_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign io_spi_miso    = (state_q == ST_SHIFT) ? tx_shift_q[DATA_WIDTH-1] : 1'b1;
  assign io_tx_ready    = ~hold_full_q;
  assign io_rx_valid    = rx_valid_q;
  assign io_rx_payload  = rx_payload_q;
  assign io_tx_underrun = tx_underrun_q;
  assign io_busy        = ~ss_s;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign io_spi_miso_writeEnable = (state_q == ST_SHIFT);
`endif

endmodule
